// File: rtl/key_debouncer.sv
// -----------------------------------------------------------------------------
// key_debouncer
//
// Cleans the raw mode push-button before it reaches the mode controller.
// The raw input is mapped to "1 = pressed" and passed through a two-flop
// synchroniser. A counter-based FSM then requires DEBOUNCE_CYCLES consecutive
// stable samples before it accepts a press or a release. It produces a
// glitch-free level and single-cycle press and release pulses.
//
// key_level drives the mode controller's state advance, so it must toggle
// exactly once per physical press.
//
// Optional feature, selected by the macro KEY_DEBOUNCER_REPEAT_EN:
//   When the macro is defined, key_press also pulses while the key is held.
//   The first repeat comes REPEAT_DELAY cycles after the press is accepted.
//   Later repeats follow every REPEAT_PERIOD cycles.
//   When the macro is undefined, no repeat logic is built and the REPEAT_*
//   parameters are ignored.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable cycles needed to accept a change (>= 2)
//   KEY_ACTIVE_LOW  : 1 = raw key low means pressed, 0 = raw key high
//   REPEAT_DELAY    : cycles from accepted press to the first repeat pulse
//   REPEAT_PERIOD   : cycles between later repeat pulses
//
// Ports:
//   clk         : system clock, rising edge
//   rst_n       : asynchronous active-low reset
//   key_in      : raw, asynchronous, bouncing button
//   key_level   : debounced state, 1 = pressed (registered)
//   key_press   : 1-cycle pulse on accepted press and on repeats (registered)
//   key_release : 1-cycle pulse on accepted release (registered)
// -----------------------------------------------------------------------------
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_level,
    output logic key_press,
    output logic key_release
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             s1;
    logic             s2;
    logic             raw_p;
    logic             release_done;

    // Normalise polarity so the rest of the block always sees 1 = pressed.
    assign raw_p = key_in ^ (KEY_ACTIVE_LOW != 0);

    // This is the last cycle of release acceptance. The repeat logic must stay
    // quiet here so that key_press and key_release are never high together.
    assign release_done = (state == RELEASE_WAIT) && !s2 && (cnt == CNT_LAST);

`ifdef KEY_DEBOUNCER_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W   = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;
    localparam logic [REP_W-1:0] REP_DELAY_LAST  = REP_W'(REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] REP_PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);

    logic [REP_W-1:0] rep_cnt;
    logic             rep_first;
    logic             rep_hit;

    // The first interval after acceptance is the delay; all later ones are the period.
    assign rep_hit = (rep_cnt == (rep_first ? REP_DELAY_LAST : REP_PERIOD_LAST));
`else
    logic unused_repeat_params;
    assign unused_repeat_params = ^{REPEAT_DELAY[0], REPEAT_PERIOD[0]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_press   <= 1'b0;
            key_release <= 1'b0;
`ifdef KEY_DEBOUNCER_REPEAT_EN
            rep_cnt     <= '0;
            rep_first   <= 1'b1;
`endif
        end else begin
            // Synchroniser for the asynchronous button.
            s1 <= raw_p;
            s2 <= s1;

            key_press   <= 1'b0;
            key_release <= 1'b0;

            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state     <= PRESSED;
                        key_level <= 1'b1;
                        key_press <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    if (s2) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state       <= IDLE;
                        key_level   <= 1'b0;
                        key_release <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase

`ifdef KEY_DEBOUNCER_REPEAT_EN
            // The repeat timer runs only while the key is accepted as held,
            // including bounces back from RELEASE_WAIT. Everywhere else it is
            // held cleared, so it starts at 0 on entry from PRESS_WAIT.
            if ((state == PRESSED) || ((state == RELEASE_WAIT) && !release_done)) begin
                if (rep_hit) begin
                    key_press <= 1'b1;
                    rep_cnt   <= '0;
                    rep_first <= 1'b0;
                end else begin
                    rep_cnt <= rep_cnt + 1'b1;
                end
            end else begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_key_debouncer.sv
// -----------------------------------------------------------------------------
// tb_key_debouncer
//
// Directed test of key_debouncer with D = 4, REPEAT_DELAY = 10,
// REPEAT_PERIOD = 5 and an active-low key.
//
// The stimulus pushes the expected output events (level edges and pulses,
// each with its cycle number) into a queue. A negedge monitor turns every
// observed output event into a pop-and-compare.
// -----------------------------------------------------------------------------
module tb_key_debouncer;

    localparam int D      = 4;
    localparam int RDELAY = 10;
    localparam int RPER   = 5;

    localparam int EV_RISE  = 0;
    localparam int EV_PRESS = 1;
    localparam int EV_FALL  = 2;
    localparam int EV_REL   = 3;

    typedef struct {
        int kind;
        int cyc;
    } ev_t;

    logic clk;
    logic rst_n;
    logic key_in;
    logic key_level;
    logic key_press;
    logic key_release;

    int   cyc;
    int   total;
    int   bad;
    logic prev_level;
    ev_t  exp_q[$];

    key_debouncer #(
        .DEBOUNCE_CYCLES(D),
        .KEY_ACTIVE_LOW (1),
        .REPEAT_DELAY   (RDELAY),
        .REPEAT_PERIOD  (RPER)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .key_in     (key_in),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_release(key_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Number of rising edges seen so far. Read at negedge, it names the edge just past.
    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic string ev_name(input int k);
        case (k)
            EV_RISE:  return "level_rise";
            EV_PRESS: return "press";
            EV_FALL:  return "level_fall";
            default:  return "release";
        endcase
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        total++;
        if (act != expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic push_ev(input int k, input int c);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int k);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_%s: got event at cycle %0d expected none", ev_name(k), cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc) begin
                bad++;
                $display("FAIL event_order: got %s at cycle %0d expected %s at cycle %0d",
                         ev_name(k), cyc, ev_name(e.kind), e.cyc);
            end
        end
    endtask

    // Monitor: every output event seen on the DUT is matched against the queue.
    always @(negedge clk) begin
        if (rst_n) begin
            if (key_level && !prev_level) check_ev(EV_RISE);
            if (key_press)                check_ev(EV_PRESS);
            if (!key_level && prev_level) check_ev(EV_FALL);
            if (key_release)              check_ev(EV_REL);
            prev_level = key_level;
        end else begin
            prev_level = 1'b0;
        end
    end

    // Press at the current negedge (unless already held), hold for `hold` cycles
    // after acceptance, then release. An optional 2-cycle release glitch is
    // inserted `glitch` cycles after acceptance. A sample taken at edge n+1
    // gives outputs after edge n+1+D+2.
    task automatic press_hold(input int hold, input bit already, input int glitch);
        int n;
        int a;
        int r;
        n = cyc;
        a = n + D + 3;
        r = a + hold;
        push_ev(EV_RISE, a);
        push_ev(EV_PRESS, a);
`ifdef KEY_DEBOUNCER_REPEAT_EN
        for (int t = a + RDELAY; t < r + D + 3; t += RPER) push_ev(EV_PRESS, t);
`endif
        push_ev(EV_FALL, r + D + 3);
        push_ev(EV_REL, r + D + 3);
        if (!already) key_in = 1'b0;
        if (glitch > 0) begin
            repeat (D + 3 + glitch) @(negedge clk);
            key_in = 1'b1;
            repeat (2) @(negedge clk);
            key_in = 1'b0;
            repeat (hold - glitch - 2) @(negedge clk);
        end else begin
            repeat (D + 3 + hold) @(negedge clk);
        end
        chk("level_held", int'(key_level), 1);
        key_in = 1'b1;
        repeat (D + 6) @(negedge clk);
        chk("level_released", int'(key_level), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        total      = 0;
        bad        = 0;
        prev_level = 1'b0;
        key_in     = 1'b0;
        rst_n      = 1'b1;
        #1 rst_n   = 1'b0;

        // Reset with the key already held: outputs stay 0 throughout.
        repeat (3) begin
            @(negedge clk);
            chk("reset_level", int'(key_level), 0);
            chk("reset_press", int'(key_press), 0);
            chk("reset_release", int'(key_release), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        press_hold(20, 1'b1, 0);

        // Clean press and release.
        press_hold(20, 1'b0, 0);

        // Bounce rejection: 2-cycle segments never reach acceptance.
        key_in = 1'b0;
        repeat (2) @(negedge clk);
        key_in = 1'b1;
        repeat (2) @(negedge clk);
        key_in = 1'b0;
        repeat (2) @(negedge clk);
        key_in = 1'b1;
        repeat (20) @(negedge clk);
        chk("bounce_level", int'(key_level), 0);

        // Release glitch while pressed.
        press_hold(20, 1'b0, 8);

        // Asynchronous reset in PRESS_WAIT with cnt = 2, key kept held.
        key_in = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("async_rst_level", int'(key_level), 0);
        chk("async_rst_press", int'(key_press), 0);
        chk("async_rst_release", int'(key_release), 0);
        @(negedge clk);
        rst_n = 1'b1;
        press_hold(20, 1'b1, 0);

        // Long hold (repeat pulses only when the feature is built).
        press_hold(31, 1'b0, 0);

        repeat (5) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
